// File: rtl/isp_rd_sched_pkg.sv
// Shared types and sizing for the ISP frame read scheduler.
package isp_rd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4,
    ST_ERR  = 3'd5
  } sched_state_e;

  // Bits needed to hold 'value'; never returns less than 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int C_NUM_BUF_MAX = 4;
  localparam int C_BUF_IDX_W   = clogb2(C_NUM_BUF_MAX - 1);

endpackage

// File: rtl/isp_rd_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches limit-1 without a clear.
module isp_rd_watchdog #(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [C_CNT_WIDTH-1:0] i_limit,
  output logic                   o_expire
);

  localparam logic [C_CNT_WIDTH-1:0] C_ONE = 1;

  logic [C_CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign o_expire = i_en && !i_clr && (i_limit != '0) && (r_cnt == i_limit - C_ONE);

endmodule

// File: rtl/isp_frame_rd_sched.sv
// Frame-level scheduler for the ISP AXI4 burst read engine: walks a ring of
// frame buffers, tracks AR/R completion, and reports timeout/overrun/config errors.
module isp_frame_rd_sched
  import isp_rd_sched_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_START_GAP  = 3
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  M_AXI_ARESET,
  input  logic                                  CFG_ENABLE,
  input  logic                                  CFG_ONESHOT,
  input  logic [C_BUF_IDX_W-1:0]                CFG_NUM_BUF,
  input  logic [C_NUM_BUF_MAX*C_ADDR_WIDTH-1:0] CFG_BASE_ADDRS,
  input  logic [31:0]                           CFG_BURSTS,
  input  logic [31:0]                           CFG_TIMEOUT,
  input  logic                                  ABORT,
  input  logic                                  CLR_ERR,
  input  logic                                  AR_HS,
  input  logic                                  R_HS,
  input  logic                                  R_LAST_HS,
  output logic                                  READ_START,
  output logic [31:0]                           BURST_ONE_FRAME_TOTAL,
  output logic [C_ADDR_WIDTH-1:0]               FRAME_BASE_ADDR,
  output logic [C_BUF_IDX_W-1:0]                BUF_IDX,
  output logic [31:0]                           FRAME_CNT,
  output logic                                  BUSY,
  output logic                                  FRAME_DONE,
  output logic                                  ERR_TIMEOUT,
  output logic                                  ERR_OVERRUN,
  output logic                                  ERR_CFG
);

  localparam logic [31:0]            C_ONE32   = 32'd1;
  localparam logic [31:0]            C_GAP_END = 32'(C_START_GAP - 1);
  localparam logic [C_BUF_IDX_W-1:0] C_IDX_ONE = 1;

  sched_state_e r_state, w_state_next;

  logic                    r_read_start, r_busy, r_frame_done, r_oneshot_pend;
  logic                    r_err_timeout, r_err_overrun, r_err_cfg;
  logic [31:0]             r_total, r_timeout, r_ar_cnt, r_rlast_cnt, r_gap_cnt, r_frame_cnt;
  logic [C_ADDR_WIDTH-1:0] r_base;
  logic [C_BUF_IDX_W-1:0]  r_buf_idx, r_num_buf;

  logic w_start, w_complete, w_overrun, w_timeout, w_cfg_err, w_wdog_expire;
  logic [C_ADDR_WIDTH-1:0] w_base [C_NUM_BUF_MAX];

  for (genvar gi = 0; gi < C_NUM_BUF_MAX; gi++) begin : g_base
    assign w_base[gi] = CFG_BASE_ADDRS[gi*C_ADDR_WIDTH +: C_ADDR_WIDTH];
  end

  assign w_start    = CFG_ENABLE || CFG_ONESHOT || r_oneshot_pend;
  assign w_complete = R_LAST_HS && (r_rlast_cnt == r_total - C_ONE32);
  assign w_overrun  = (r_state == ST_RUN) && AR_HS && (r_ar_cnt >= r_total);

  isp_rd_watchdog #(.C_CNT_WIDTH(32)) u_wdog (
    .i_clk    (M_AXI_ACLK),
    .i_srst   (M_AXI_ARESET),
    .i_en     (r_state == ST_RUN),
    .i_clr    ((r_state == ST_LOAD) || AR_HS || R_HS),
    .i_limit  (r_timeout),
    .o_expire (w_wdog_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_cfg_err    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (CFG_BURSTS == '0) w_cfg_err = 1'b1;
          else                  w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: w_state_next = ST_RUN;
      ST_RUN: begin
        if (ABORT) begin
          w_state_next = ST_GAP;
        end else if (w_complete) begin
          w_state_next = ST_DONE;
        end else if (w_wdog_expire) begin
          w_timeout    = 1'b1;
          w_state_next = ST_ERR;
        end
      end
      ST_DONE: w_state_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt == C_GAP_END) w_state_next = ST_IDLE;
      ST_ERR:  if (CLR_ERR) w_state_next = ST_GAP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state        <= ST_IDLE;
      r_read_start   <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_oneshot_pend <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_err_cfg      <= 1'b0;
      r_total        <= '0;
      r_timeout      <= '0;
      r_ar_cnt       <= '0;
      r_rlast_cnt    <= '0;
      r_gap_cnt      <= '0;
      r_frame_cnt    <= '0;
      r_base         <= '0;
      r_buf_idx      <= '0;
      r_num_buf      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_read_start <= (w_state_next == ST_RUN);
      r_busy       <= (w_state_next != ST_IDLE);
      r_frame_done <= (w_state_next == ST_DONE);

      // A oneshot pulse seen outside IDLE waits here until the next start.
      if ((r_state == ST_IDLE) && w_start) r_oneshot_pend <= 1'b0;
      else if (CFG_ONESHOT)                r_oneshot_pend <= 1'b1;

      if (r_state == ST_LOAD) begin
        r_total     <= CFG_BURSTS;
        r_timeout   <= CFG_TIMEOUT;
        r_num_buf   <= CFG_NUM_BUF;
        r_base      <= w_base[r_buf_idx];
        r_ar_cnt    <= '0;
        r_rlast_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        if (AR_HS)     r_ar_cnt    <= r_ar_cnt + C_ONE32;
        if (R_LAST_HS) r_rlast_cnt <= r_rlast_cnt + C_ONE32;
      end

      // '>=' also covers a ring that shrank below the current index.
      if (r_state == ST_DONE) begin
        r_frame_cnt <= r_frame_cnt + C_ONE32;
        r_buf_idx   <= (r_buf_idx >= r_num_buf) ? '0 : r_buf_idx + C_IDX_ONE;
      end

      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + C_ONE32 : '0;

      r_err_timeout <= (r_err_timeout && !CLR_ERR) || w_timeout;
      r_err_overrun <= (r_err_overrun && !CLR_ERR) || w_overrun;
      r_err_cfg     <= (r_err_cfg     && !CLR_ERR) || w_cfg_err;
    end
  end

  assign READ_START            = r_read_start;
  assign BURST_ONE_FRAME_TOTAL = r_total;
  assign FRAME_BASE_ADDR       = r_base;
  assign BUF_IDX               = r_buf_idx;
  assign FRAME_CNT             = r_frame_cnt;
  assign BUSY                  = r_busy;
  assign FRAME_DONE            = r_frame_done;
  assign ERR_TIMEOUT           = r_err_timeout;
  assign ERR_OVERRUN           = r_err_overrun;
  assign ERR_CFG               = r_err_cfg;

endmodule

// File: tb/tb_isp_frame_rd_sched.sv
// Directed bench for isp_frame_rd_sched: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand per vector.
module tb_isp_frame_rd_sched;

  logic         clk = 1'b0;
  logic         srst;
  logic         cfg_enable, cfg_oneshot, abort, clr_err, ar_hs, r_hs, r_last_hs;
  logic [1:0]   cfg_num_buf;
  logic [127:0] cfg_base_addrs;
  logic [31:0]  cfg_bursts, cfg_timeout;
  logic         read_start, busy, frame_done, err_timeout, err_overrun, err_cfg;
  logic [31:0]  burst_total, frame_base_addr, frame_cnt;
  logic [1:0]   buf_idx;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  isp_frame_rd_sched dut (
    .M_AXI_ACLK            (clk),
    .M_AXI_ARESET          (srst),
    .CFG_ENABLE            (cfg_enable),
    .CFG_ONESHOT           (cfg_oneshot),
    .CFG_NUM_BUF           (cfg_num_buf),
    .CFG_BASE_ADDRS        (cfg_base_addrs),
    .CFG_BURSTS            (cfg_bursts),
    .CFG_TIMEOUT           (cfg_timeout),
    .ABORT                 (abort),
    .CLR_ERR               (clr_err),
    .AR_HS                 (ar_hs),
    .R_HS                  (r_hs),
    .R_LAST_HS             (r_last_hs),
    .READ_START            (read_start),
    .BURST_ONE_FRAME_TOTAL (burst_total),
    .FRAME_BASE_ADDR       (frame_base_addr),
    .BUF_IDX               (buf_idx),
    .FRAME_CNT             (frame_cnt),
    .BUSY                  (busy),
    .FRAME_DONE            (frame_done),
    .ERR_TIMEOUT           (err_timeout),
    .ERR_OVERRUN           (err_overrun),
    .ERR_CFG               (err_cfg)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ar(input int n);
    for (int i = 0; i < n; i++) begin
      ar_hs = 1'b1;
      @(negedge clk);
      ar_hs = 1'b0;
    end
  endtask

  task automatic pulse_rlast(input int n);
    for (int i = 0; i < n; i++) begin
      r_hs = 1'b1; r_last_hs = 1'b1;
      @(negedge clk);
      r_hs = 1'b0; r_last_hs = 1'b0;
    end
  endtask

  task automatic oneshot();
    cfg_oneshot = 1'b1;
    @(negedge clk);
    cfg_oneshot = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 20 && read_start !== 1'b1; i++) @(negedge clk);
    check_val(tag, read_start, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    check_val(tag, busy, 0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step(2);
    srst = 1'b0;
  endtask

  initial begin
    logic [31:0] ring_base [4];
    ring_base[0] = 32'h1000; ring_base[1] = 32'h2000;
    ring_base[2] = 32'h3000; ring_base[3] = 32'h1000;

    srst = 1'b1;
    cfg_enable = 0; cfg_oneshot = 0; abort = 0; clr_err = 0;
    ar_hs = 0; r_hs = 0; r_last_hs = 0;
    cfg_num_buf = 2'd1; cfg_bursts = 32'd4; cfg_timeout = 32'd0;
    cfg_base_addrs = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    step(3);
    srst = 1'b0;
    step(1);
    check_val("rst_read_start", read_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_buf_idx", buf_idx, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    check_val("rst_errs", {err_timeout, err_overrun, err_cfg, frame_done}, 0);

    // Oneshot frame, 4 bursts, ring of 2
    oneshot();
    check_val("os_load_busy", busy, 1);
    check_val("os_load_start", read_start, 0);
    step(1);
    check_val("os_run_start", read_start, 1);
    check_val("os_base", frame_base_addr, 32'h1000);
    check_val("os_total", burst_total, 4);
    pulse_ar(4);
    pulse_rlast(4);
    check_val("os_done", frame_done, 1);
    check_val("os_done_start", read_start, 0);
    step(1);
    check_val("os_done_pulse", frame_done, 0);
    check_val("os_frame_cnt", frame_cnt, 1);
    check_val("os_buf_idx", buf_idx, 1);
    step(2);
    check_val("os_gap_busy", {busy, read_start}, 2'b10);
    step(1);
    check_val("os_idle", {busy, read_start}, 2'b00);

    // Continuous ring of 3 buffers
    do_reset();
    cfg_num_buf = 2'd2; cfg_bursts = 32'd2; cfg_enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_run("ring_run");
      check_val($sformatf("ring_base%0d", f), frame_base_addr, ring_base[f]);
      check_val($sformatf("ring_idx%0d", f), buf_idx, f % 3);
      pulse_ar(2);
      pulse_rlast(2);
      if (f == 3) cfg_enable = 1'b0;
    end
    wait_idle("ring_idle");
    check_val("ring_frame_cnt", frame_cnt, 4);
    check_val("ring_idx_end", buf_idx, 1);

    // Watchdog: stall after 2 ARs
    do_reset();
    cfg_bursts = 32'd4; cfg_timeout = 32'd10;
    oneshot();
    wait_run("wd_run");
    pulse_ar(2);
    step(9);
    check_val("wd_not_yet", {err_timeout, read_start}, 2'b01);
    step(1);
    check_val("wd_expire", {err_timeout, read_start, busy}, 3'b101);
    step(3);
    check_val("wd_hold_err", {err_timeout, busy}, 2'b11);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check_val("wd_clr", {err_timeout, busy}, 2'b01);
    step(2);
    check_val("wd_gap", busy, 1);
    step(1);
    check_val("wd_idle", busy, 0);

    // ABORT coincident with final RLAST
    cfg_timeout = 32'd0; cfg_bursts = 32'd2;
    oneshot();
    wait_run("ab_run");
    pulse_ar(2);
    pulse_rlast(1);
    abort = 1'b1; r_hs = 1'b1; r_last_hs = 1'b1;
    step(1);
    abort = 1'b0; r_hs = 1'b0; r_last_hs = 1'b0;
    check_val("ab_no_done", {frame_done, read_start, busy}, 3'b001);
    step(1);
    check_val("ab_no_done2", frame_done, 0);
    check_val("ab_frame_cnt", frame_cnt, 0);
    check_val("ab_buf_idx", buf_idx, 0);
    step(2);
    check_val("ab_idle", busy, 0);

    // Config error and overrun
    cfg_bursts = 32'd0;
    oneshot();
    check_val("cfg_err", {err_cfg, busy, read_start}, 3'b100);
    step(3);
    check_val("cfg_no_start", {read_start, busy}, 2'b00);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check_val("cfg_clr", err_cfg, 0);
    cfg_bursts = 32'd2;
    oneshot();
    wait_run("ov_run");
    pulse_ar(2);
    check_val("ov_none", err_overrun, 0);
    pulse_ar(1);
    check_val("ov_set", {err_overrun, read_start}, 2'b11);
    pulse_rlast(2);
    check_val("ov_done", frame_done, 1);
    wait_idle("ov_idle");
    check_val("ov_sticky", err_overrun, 1);

    // Reset mid-RUN
    cfg_bursts = 32'd4;
    oneshot();
    wait_run("mr_run");
    pulse_ar(2);
    srst = 1'b1;
    step(1);
    check_val("mr_outputs", {read_start, busy, frame_done, err_overrun}, 4'b0000);
    check_val("mr_buf_idx", buf_idx, 0);
    check_val("mr_frame_cnt", frame_cnt, 0);
    check_val("mr_latches", {burst_total, frame_base_addr}, 64'd0);
    srst = 1'b0;
    step(2);
    check_val("mr_stay_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

endmodule
